multicycle_control: RTL
=======================

// Module: multicycle_control
// PURPOSE
// - Moore/Mealy control FSM for the multicycle MIPS-subset core; sits directly upstream of the ALU.
// - Decodes op/funct, sequences fetch/decode/execute/memory/writeback, and drives alu_control[2:0] plus all datapath mux selects and write strobes.
// - Stretches memory states on mem_ready wait-states. Flags unsupported opcodes.
// PARAMETERS
// - None. All encodings are fixed constants in ctrl_defs.vh.
// PORTS
// clk          in   1  rising-edge clock
// reset_n      in   1  asynchronous, active-low reset
// op           in   6  instr[31:26] from instruction register
// funct        in   6  instr[5:0]
// mem_ready    in   1  memory access completes this cycle
// ir_write     out  1  load instruction register
// pc_write     out  1  unconditional PC update
// branch       out  1  PC update if ALU zero (datapath ANDs with zero)
// mem_write    out  1  data memory write strobe
// reg_write    out  1  register file write strobe
// ior          out  1  mem addr: 0=PC, 1=ALUOut
// mem_to_reg   out  1  WB data: 0=ALUOut, 1=Data reg
// reg_dst      out  1  dest: 0=rt, 1=rd
// alu_src_a    out  1  0=PC, 1=A reg
// alu_src_b    out  2  00=B, 01=const 4, 10=sign-ext imm, 11=imm<<2
// pc_src       out  2  00=ALU result, 01=ALUOut, 10=jump target
// alu_control  out  3  000 add, 001 sub, 010 and, 011 or, 101 slt, 110 mul
// illegal_op   out  1  one-cycle pulse on unsupported opcode
// BEHAVIOUR
// - Clock and reset: one clock. reset_n low asynchronously forces state RST.
// - RST: all outputs 0, alu_control=000. First edge with reset_n high -> FETCH.
// - Output timing: strobes are combinational from state; only FETCH/MEMRD/MEMWR also use mem_ready.
// - Unlisted outputs are 0 in every state.
// - FETCH: ior=0, alu_src_a=0, alu_src_b=01, alu_control=000, pc_src=00.
//   - ir_write = pc_write = mem_ready.
//   - Stay in FETCH while !mem_ready; -> DECODE on mem_ready.
// - DECODE: alu_src_a=0, alu_src_b=11, alu_control=000 (branch target precompute). Next state by op:
//   - 100011 lw / 101011 sw -> MEMADR
//   - 000000 R -> EXEC
//   - 000100 beq -> BEQ
//   - 001000 addi -> ADDIEX
//   - 000010 j -> JUMP
//   - anything else -> FETCH, with illegal_op=1 this cycle only; no strobes.
// - MEMADR: alu_src_a=1, alu_src_b=10, alu_control=000. lw -> MEMRD, sw -> MEMWR.
// - MEMRD: ior=1. Hold while !mem_ready; -> MEMWB.
// - MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. -> FETCH.
// - MEMWR: ior=1, mem_write=1 held every cycle until mem_ready; -> FETCH.
// - EXEC: alu_src_a=1, alu_src_b=00, alu_control from funct:
//   - 100000 -> 000; 100010 -> 001; 100100 -> 010; 100101 -> 011; 101010 -> 101; 011000 -> 110
//   - other funct -> 000
//   - -> ALUWB.
// - ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. -> FETCH.
// - BEQ: alu_src_a=1, alu_src_b=00, alu_control=001, pc_src=01, branch=1. -> FETCH.
// - ADDIEX: alu_src_a=1, alu_src_b=10, alu_control=000. -> ADDIWB.
// - ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. -> FETCH.
// - JUMP: pc_src=10, pc_write=1. -> FETCH.
// - Instruction latency in cycles (zero wait):
//   - lw 5; sw 4; R/addi 4; beq 3; j 3; illegal 2.
//   - Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds exactly one cycle.
// - Reset mid-instruction: immediate return to RST. No strobe may glitch high after reset_n falls.
// - op/funct are sampled only in DECODE/EXEC; the IR holds them stable after FETCH.
// - State register: binary, 4 bits. Unreachable codes -> RST on the next edge.
// STRUCTURE
// - ctrl_defs.vh (shared): state codes, opcode and funct constants, alu_control codes, alu_src_b/pc_src codes.
//   - The ALU and datapath include the same header.
// - Sub-module alu_decoder (combinational): alu_op[1:0] (00 add, 01 sub, 10 funct) + funct -> alu_control.
//   - The FSM drives alu_op; alu_decoder produces alu_control.
// TESTING
// 1. Reset then lw, mem_ready=1 throughout:
//    - state trace RST,FETCH,DECODE,MEMADR,MEMRD,MEMWB.
//    - reg_write=1 and mem_to_reg=1 only in MEMWB.
// 2. R-type funct=101010 (slt):
//    - alu_control=101 in EXEC; reg_write=1, reg_dst=1 in ALUWB; 4 cycles total.
// 3. sw with mem_ready low 3 cycles in MEMWR:
//    - mem_write high 4 consecutive cycles, then FETCH.
// 4. FETCH with mem_ready=0 for 2 cycles:
//    - ir_write=pc_write=0 for 2 cycles, then 1 for one cycle; -> DECODE.
// 5. beq: alu_control=001, branch=1, pc_src=01 for exactly one cycle.
//    j: pc_src=10, pc_write=1 for one cycle.
// 6. op=111111:
//    - illegal_op pulses once in DECODE, no strobes, next state FETCH.
//    - Then drop reset_n during MEMRD: all outputs 0 immediately; RST->FETCH after release.

Source files
------------

// File: rtl/multicycle_control_pkg.sv
// Shared encodings for the multicycle control FSM: state codes, opcode/funct
// values, ALU operation codes and datapath mux select codes.
package multicycle_control_pkg;

  typedef enum logic [3:0] {
    ST_RST    = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_ALUWB  = 4'd8,
    ST_BEQ    = 4'd9,
    ST_ADDIEX = 4'd10,
    ST_ADDIWB = 4'd11,
    ST_JUMP   = 4'd12
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;
  localparam logic [5:0] FUNCT_MUL = 6'b011000;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_MUL = 3'b110;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRC_B_REG    = 2'b00;
  localparam logic [1:0] SRC_B_FOUR   = 2'b01;
  localparam logic [1:0] SRC_B_IMM    = 2'b10;
  localparam logic [1:0] SRC_B_BRANCH = 2'b11;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Opcodes the FSM knows how to sequence; everything else raises illegal_op.
  function automatic logic is_supported_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW) || (op == OP_RTYPE) ||
           (op == OP_BEQ) || (op == OP_ADDI) || (op == OP_J);
  endfunction

endpackage

// File: rtl/multicycle_control_alu_decoder.sv
// Combinational ALU decoder: turns the FSM's coarse alu_op plus the R-type
// funct field into the 3-bit alu_control code seen by the ALU.
module multicycle_control_alu_decoder
  import multicycle_control_pkg::*;
(
  input  logic [1:0] alu_op,
  input  logic [5:0] funct,
  output logic [2:0] alu_control
);

  // Unknown funct values fall back to add so the ALU never sees a reserved code.
  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD: alu_control = ALU_ADD;
      ALUOP_SUB: alu_control = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: alu_control = ALU_ADD;
          FUNCT_SUB: alu_control = ALU_SUB;
          FUNCT_AND: alu_control = ALU_AND;
          FUNCT_OR:  alu_control = ALU_OR;
          FUNCT_SLT: alu_control = ALU_SLT;
          FUNCT_MUL: alu_control = ALU_MUL;
          default:   alu_control = ALU_ADD;
        endcase
      end
      default: alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Control FSM of the multicycle MIPS-subset core: sequences each instruction
// through its states and drives every datapath mux select and write strobe.
module multicycle_control
  import multicycle_control_pkg::*;
(
  input  logic       clk,
  input  logic       reset_n,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       mem_ready,
  output logic       ir_write,
  output logic       pc_write,
  output logic       branch,
  output logic       mem_write,
  output logic       reg_write,
  output logic       ior,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [1:0] pc_src,
  output logic [2:0] alu_control,
  output logic       illegal_op
);

  state_t     state;
  state_t     next_state;
  logic       is_store;
  logic [1:0] alu_op;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= ST_RST;
    else          state <= next_state;
  end

  // op is only trusted in DECODE, so MEMADR uses this captured load/store choice.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 is_store <= 1'b0;
    else if (state == ST_DECODE)  is_store <= (op == OP_SW);
  end

  always_comb begin
    next_state = ST_RST;
    case (state)
      ST_RST:    next_state = ST_FETCH;
      ST_FETCH:  next_state = mem_ready ? ST_DECODE : ST_FETCH;
      ST_DECODE: begin
        case (op)
          OP_LW, OP_SW: next_state = ST_MEMADR;
          OP_RTYPE:     next_state = ST_EXEC;
          OP_BEQ:       next_state = ST_BEQ;
          OP_ADDI:      next_state = ST_ADDIEX;
          OP_J:         next_state = ST_JUMP;
          default:      next_state = ST_FETCH;
        endcase
      end
      ST_MEMADR: next_state = is_store ? ST_MEMWR : ST_MEMRD;
      ST_MEMRD:  next_state = mem_ready ? ST_MEMWB : ST_MEMRD;
      ST_MEMWB:  next_state = ST_FETCH;
      ST_MEMWR:  next_state = mem_ready ? ST_FETCH : ST_MEMWR;
      ST_EXEC:   next_state = ST_ALUWB;
      ST_ALUWB:  next_state = ST_FETCH;
      ST_BEQ:    next_state = ST_FETCH;
      ST_ADDIEX: next_state = ST_ADDIWB;
      ST_ADDIWB: next_state = ST_FETCH;
      ST_JUMP:   next_state = ST_FETCH;
      default:   next_state = ST_RST;
    endcase
  end

  // Outputs follow the state directly so an async reset clears them instantly.
  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    branch     = 1'b0;
    mem_write  = 1'b0;
    reg_write  = 1'b0;
    ior        = 1'b0;
    mem_to_reg = 1'b0;
    reg_dst    = 1'b0;
    alu_src_a  = 1'b0;
    alu_src_b  = SRC_B_REG;
    pc_src     = PC_SRC_ALU;
    alu_op     = ALUOP_ADD;
    illegal_op = 1'b0;
    case (state)
      ST_FETCH: begin
        alu_src_b = SRC_B_FOUR;
        ir_write  = mem_ready;
        pc_write  = mem_ready;
      end
      ST_DECODE: begin
        alu_src_b  = SRC_B_BRANCH;
        illegal_op = !is_supported_op(op);
      end
      ST_MEMADR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      ST_MEMRD: ior = 1'b1;
      ST_MEMWB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      ST_MEMWR: begin
        ior       = 1'b1;
        mem_write = 1'b1;
      end
      ST_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
      end
      ST_ALUWB: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      ST_BEQ: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_SUB;
        pc_src    = PC_SRC_ALUOUT;
        branch    = 1'b1;
      end
      ST_ADDIEX: begin
        alu_src_a = 1'b1;
        alu_src_b = SRC_B_IMM;
      end
      ST_ADDIWB: reg_write = 1'b1;
      ST_JUMP: begin
        pc_src   = PC_SRC_JUMP;
        pc_write = 1'b1;
      end
      default: ;
    endcase
  end

  multicycle_control_alu_decoder u_alu_decoder (
    .alu_op      (alu_op),
    .funct       (funct),
    .alu_control (alu_control)
  );

endmodule
